// File: rtl/ps2_key_sequencer.sv
// PS/2 frame receiver in the system clock domain: validates 11-bit frames,
// folds E0/F0 prefixes into key events and queues them behind valid/ready.
module ps2_key_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned EW = 10;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]    state, state_nx;
  logic          ps2_clk_q;
  logic          fe;
  logic [7:0]    sreg, sreg_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic          par_q, par_nx;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic          ext_q, ext_nx, brk_q, brk_nx;
  logic          perr_nx, ferr_nx, ovf_nx, push;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic          empty, full, pop, push_ok;

  assign fe = ps2_clk_q & ~ps2_clk;

  // Frame FSM, timeout watchdog and prefix folding
  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_cnt_nx = bit_cnt;
    par_nx     = par_q;
    ext_nx     = ext_q;
    brk_nx     = brk_q;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    push       = 1'b0;
    if (state == IDLE || fe) tmo_nx = '0;
    else                     tmo_nx = TW'(tmo_cnt + 1'b1);

    case (state)
      IDLE: begin
        if (fe && !ps2_data) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
      end
      DATA: begin
        if (fe) begin
          sreg_nx    = {ps2_data, sreg[7:1]};
          bit_cnt_nx = 3'(bit_cnt + 3'd1);
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
      end
      PARITY: begin
        if (fe) begin
          par_nx   = ps2_data;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          state_nx = IDLE;
          if (!(^{sreg, par_q}))   perr_nx = 1'b1;
          else if (!ps2_data)      ferr_nx = 1'b1;
          else if (sreg == 8'hE0)  ext_nx  = 1'b1;
          else if (sreg == 8'hF0)  brk_nx  = 1'b1;
          else begin
            push   = 1'b1;
            ext_nx = 1'b0;
            brk_nx = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (state != IDLE && !fe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_nx = IDLE;
      ferr_nx  = 1'b1;
      tmo_nx   = '0;
    end
    if (perr_nx || ferr_nx) begin
      ext_nx = 1'b0;
      brk_nx = 1'b0;
    end
  end

  // Event FIFO control; a pop frees the slot for a same-cycle push
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = evt_valid & evt_ready;
  assign push_ok = push & (~full | pop);
  assign ovf_nx  = push & full & ~pop;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign evt_valid = ~empty;
  assign evt_code  = empty ? 8'h00 : head[7:0];
  assign evt_break = empty ? 1'b0  : head[8];
  assign evt_ext   = empty ? 1'b0  : head[9];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ps2_clk_q  <= 1'b1;
      sreg       <= '0;
      bit_cnt    <= '0;
      par_q      <= 1'b0;
      tmo_cnt    <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      ps2_clk_q  <= ps2_clk;
      sreg       <= sreg_nx;
      bit_cnt    <= bit_cnt_nx;
      par_q      <= par_nx;
      tmo_cnt    <= tmo_nx;
      ext_q      <= ext_nx;
      brk_q      <= brk_nx;
      err_parity <= perr_nx;
      err_frame  <= ferr_nx;
      overflow   <= ovf_nx;
      busy       <= (state_nx != IDLE);
      if (push_ok) wr_ptr <= PW'(wr_ptr + 1'b1);
      if (pop)     rd_ptr <= PW'(rd_ptr + 1'b1);
    end
  end

  // Storage needs no reset: entries are only visible between the pointers
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr[AW-1:0]] <= {ext_q, brk_q, sreg};
  end

endmodule
